// File: rtl/cussen_pkg.sv
// Shared types and constants for the cussen decoder: frame widths, FSM states and packed bus payloads.
package cussen_pkg;

    localparam int unsigned N_ELEM = 9;
    localparam int unsigned W_DATA = 8;
    localparam int unsigned W_PTR  = 4;

    localparam logic [W_PTR-1:0] PTR_NONE  = 4'hF;
    localparam logic [W_PTR-1:0] COUNT_MAX = W_PTR'(N_ELEM);
    localparam logic [W_PTR-1:0] LAST_IDX  = W_PTR'(N_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        MAP,
        DONE
    } dec_state_t;

    typedef logic [N_ELEM-1:0][W_DATA-1:0] delta_frame_t;
    typedef logic [N_ELEM-1:0][W_DATA-1:0] data_frame_t;
    typedef logic [N_ELEM-1:0][W_PTR-1:0]  ptr_frame_t;

    // Counts above the frame size behave as a full frame.
    function automatic logic [W_PTR-1:0] clamp_count(input logic [W_PTR-1:0] c);
        return (c > COUNT_MAX) ? COUNT_MAX : c;
    endfunction

endpackage

// File: rtl/cussen_ptr_lookup.sv
// Combinational selection of one reconstructed value by pointer, with a range check against the unique count.
module cussen_ptr_lookup
    import cussen_pkg::*;
(
    input  data_frame_t       vals,
    input  logic [W_PTR-1:0]  ptr,
    input  logic [W_PTR-1:0]  count,
    output logic [W_DATA-1:0] data_c,
    output logic              hit_c
);

    always_comb begin
        data_c = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (ptr == W_PTR'(i)) begin
                data_c = vals[i];
            end
        end
        hit_c = (ptr != PTR_NONE) && (ptr < count);
    end

endmodule

// File: rtl/cussen_decoder.sv
// Rebuilds nine samples from a delta-coded sorted unique list: serial prefix sum, then serial pointer lookup.
// Optional integrity checking is built when CUSSEN_DEC_CHECK_EN is defined; otherwise err stays 0.
module cussen_decoder
    import cussen_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_ELEM*W_DATA-1:0]   delta_in,
    input  logic [W_PTR-1:0]           count_in,
    input  logic [N_ELEM*W_PTR-1:0]    ptr_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_ELEM*W_DATA-1:0]   out_data,
    output logic                       err
);

    dec_state_t        state_q, state_d;
    delta_frame_t      delta_q, delta_d;
    ptr_frame_t        ptr_q, ptr_d;
    logic [W_PTR-1:0]  cnt_q, cnt_d;
    data_frame_t       val_q, val_d;
    logic [W_PTR-1:0]  idx_q, idx_d;
    data_frame_t       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              err_q, err_d;
`ifdef CUSSEN_DEC_CHECK_EN
    logic              chk_q, chk_d;
`endif

    logic [W_DATA-1:0] acc_sum;
    logic [W_DATA-1:0] lk_data;
    logic              lk_hit;

    cussen_ptr_lookup u_lookup (
        .vals   (val_q),
        .ptr    (ptr_q[idx_q]),
        .count  (cnt_q),
        .data_c (lk_data),
        .hit_c  (lk_hit)
    );

    assign acc_sum = val_q[idx_q - W_PTR'(1)] + delta_q[idx_q];

    // Next-state and datapath updates; idx_q walks k in ACCUM and j in MAP.
    always_comb begin
        state_d     = state_q;
        delta_d     = delta_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        val_d       = val_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
`ifdef CUSSEN_DEC_CHECK_EN
        chk_d       = chk_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    delta_d = delta_frame_t'(delta_in);
                    ptr_d   = ptr_frame_t'(ptr_in);
                    cnt_d   = clamp_count(count_in);
                    val_d   = '0;
                    if (count_in != '0) begin
                        val_d[0] = delta_d[0];
                    end
                    idx_d   = W_PTR'(1);
                    state_d = ACCUM;
`ifdef CUSSEN_DEC_CHECK_EN
                    chk_d   = (count_in > COUNT_MAX);
`endif
                end
            end

            ACCUM: begin
                if (idx_q < cnt_q) begin
                    val_d[idx_q] = acc_sum;
`ifdef CUSSEN_DEC_CHECK_EN
                    // Sorted unique list must strictly increase; a zero delta or a wrap breaks that.
                    if (acc_sum <= val_q[idx_q - W_PTR'(1)]) begin
                        chk_d = 1'b1;
                    end
`endif
                end else begin
                    val_d[idx_q] = '0;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = MAP;
                end else begin
                    idx_d = idx_q + W_PTR'(1);
                end
            end

            MAP: begin
                out_data_d[idx_q] = lk_hit ? lk_data : '0;
`ifdef CUSSEN_DEC_CHECK_EN
                if (!lk_hit) begin
                    chk_d = 1'b1;
                end
`endif
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + W_PTR'(1);
                end
            end

            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
`ifdef CUSSEN_DEC_CHECK_EN
                    err_d       = chk_q;
`endif
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            delta_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            val_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef CUSSEN_DEC_CHECK_EN
            chk_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            delta_q     <= delta_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
`ifdef CUSSEN_DEC_CHECK_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cussen_decoder.sv
// Directed self-checking bench for cussen_decoder; expected err follows CUSSEN_DEC_CHECK_EN.
module tb_cussen_decoder;

`ifdef CUSSEN_DEC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] delta_in;
    logic [3:0]  count_in;
    logic [35:0] ptr_in;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] dv[9];
    logic [3:0] pv[9];
    logic [7:0] ev[9];

    always #5 clk = ~clk;

    cussen_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .delta_in  (delta_in),
        .count_in  (count_in),
        .ptr_in    (ptr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    task automatic load_frame(input logic [3:0] cnt);
        for (int i = 0; i < 9; i++) begin
            delta_in[8*i +: 8] = dv[i];
            ptr_in[4*i +: 4]   = pv[i];
        end
        count_in = cnt;
    endtask

    // Presents one frame; returns at the falling edge just after the accept edge.
    task automatic send_frame(input logic [3:0] cnt);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_in_ready got=%b exp=1", in_ready);
        end
        load_frame(cnt);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        delta_in = '0; count_in = '0; ptr_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, err} !== 3'b000 || out_data !== 72'd0) begin
            failures++;
            $display("FAIL reset_outputs got in_ready=%b out_valid=%b err=%b data=%h exp all 0",
                     in_ready, out_valid, err, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_round_trip();
        int n;
        dv = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
        pv = '{4'd2, 4'd1, 4'd2, 4'd4, 4'd1, 4'd0, 4'd0, 4'd4, 4'd3};
        ev = '{8'd5, 8'd3, 8'd5, 8'd9, 8'd3, 8'd1, 8'd1, 8'd9, 8'd7};
        send_frame(4'd5);
        wait_out(n);
        checks++;
        if (n != 18 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rt_latency got=%0d valid=%b exp=18 valid=1", n, out_valid);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (out_data[8*i +: 8] !== ev[i]) begin
                failures++;
                $display("FAIL rt_data[%0d] got=%0d exp=%0d", i, out_data[8*i +: 8], ev[i]);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL rt_err got=%b exp=0", err);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rt_after_hs got valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        int n;
        dv = '{8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        pv = '{default: 4'd0};
        send_frame(4'd1);
        wait_out(n);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[8*i +: 8] !== 8'd42) begin
                failures++;
                $display("FAIL single_data[%0d] got=%0d valid=%b exp=42", i, out_data[8*i +: 8], out_valid);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL single_err got=%b exp=0", err);
        end
        handshake();
    endtask

    task automatic test_wrap();
        int n;
        dv = '{8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        pv = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        ev = '{8'd44, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        send_frame(4'd2);
        wait_out(n);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[8*i +: 8] !== ev[i]) begin
                failures++;
                $display("FAIL wrap_data[%0d] got=%0d valid=%b exp=%0d", i, out_data[8*i +: 8], out_valid, ev[i]);
            end
        end
        checks++;
        if (err !== CHK) begin
            failures++;
            $display("FAIL wrap_err got=%b exp=%b", err, CHK);
        end
        handshake();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_err_clear got=%b exp=0", err);
        end
    endtask

    task automatic test_bad_ptr();
        int n;
        dv = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
        pv = '{4'd0, 4'd1, 4'd2, 4'hF, 4'd4, 4'd3, 4'd7, 4'd2, 4'd1};
        ev = '{8'd1, 8'd3, 8'd5, 8'd0, 8'd9, 8'd7, 8'd0, 8'd5, 8'd3};
        send_frame(4'd5);
        wait_out(n);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[8*i +: 8] !== ev[i]) begin
                failures++;
                $display("FAIL badptr_data[%0d] got=%0d valid=%b exp=%0d", i, out_data[8*i +: 8], out_valid, ev[i]);
            end
        end
        checks++;
        if (err !== CHK) begin
            failures++;
            $display("FAIL badptr_err got=%b exp=%b", err, CHK);
        end
        handshake();
    endtask

    task automatic test_back_pressure();
        int n;
        dv = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        pv = '{default: 4'd0};
        send_frame(4'd1);
        wait_out(n);
        dv = '{8'd99, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        load_frame(4'd3);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== {9{8'd7}}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got valid=%b in_ready=%b data=%h exp 1/0/%h",
                         c, out_valid, in_ready, out_data, {9{8'd7}});
            end
            @(negedge clk);
        end
        handshake();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got in_ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  saw_valid = 1'b0;
        dv = '{8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        pv = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
        send_frame(4'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, err} !== 3'b000 || out_data !== 72'd0) begin
            failures++;
            $display("FAIL midrst_outputs got in_ready=%b valid=%b err=%b data=%h exp all 0",
                     in_ready, out_valid, err, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_in_ready got=%b exp=1", in_ready);
        end
        for (int c = 0; c < 25; c++) begin
            if (out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("FAIL midrst_no_output got out_valid seen=1 exp=0");
        end
        ev = '{8'd12, 8'd7, 8'd3, 8'd12, 8'd7, 8'd3, 8'd12, 8'd7, 8'd3};
        send_frame(4'd3);
        wait_out(n);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[8*i +: 8] !== ev[i]) begin
                failures++;
                $display("FAIL midrst_data[%0d] got=%0d valid=%b exp=%0d", i, out_data[8*i +: 8], out_valid, ev[i]);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_err got=%b exp=0", err);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_single();
        test_wrap();
        test_bad_ptr();
        test_back_pressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
